// File: rtl/cpu_commit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_commit (with cpu_commit_pkg)
// Purpose  : Architectural state and commit stage of the single-cycle CPU.
//            Applies an EXECUTE record at the clock edge: PC, register file,
//            data memory, interrupt registers, a TX byte queue toward the
//            UART and an RX byte latch from it. Current state is presented
//            back to decode combinationally.
// Ports    : clk, rst_n              - clock, synchronous active-low reset
//            i_ex_valid, i_ex        - commit strobe and execute record
//            i_rd_idx                - destination register index
//            i_rs1_idx, i_rs2_idx    - read-port indices
//            o_x_rs1, o_x_rs2        - register read data
//            o_mem_rd                - mem[o_x_rs1] read data
//            o_pc, o_intr_en, o_intr_pc, o_intr_vec - special registers
//            o_w_busy                - TX queue full
//            o_r_data, o_intr_req    - last RX byte, pending-RX interrupt
//            o_tx_valid/o_tx_data/i_tx_ready - stream to UART TX
//            i_rx_valid/i_rx_data    - byte strobe from UART RX
// Revision : 1.0 - initial release
// ============================================================================

package cpu_commit_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic        w_req;
    logic [7:0]  w_data;
    logic        ack;
    logic        w_rd;
    logic [31:0] x_rd;
    logic        mem_w_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_val;
    logic        intr_en;
    logic [31:0] intr_pc;
    logic [31:0] intr_vec;
  } execute_t;
endpackage

module cpu_commit
  import cpu_commit_pkg::*;
#(
  parameter int          NREG      = 16,
  parameter int          MEM_DEPTH = 64,
  parameter int          TXQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] RESET_VEC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_valid,
  input  execute_t    i_ex,
  input  logic [3:0]  i_rd_idx,
  input  logic [3:0]  i_rs1_idx,
  input  logic [3:0]  i_rs2_idx,
  output logic [31:0] o_x_rs1,
  output logic [31:0] o_x_rs2,
  output logic [31:0] o_mem_rd,
  output logic [31:0] o_pc,
  output logic        o_intr_en,
  output logic [31:0] o_intr_pc,
  output logic [31:0] o_intr_vec,
  output logic        o_w_busy,
  output logic [7:0]  o_r_data,
  output logic        o_intr_req,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data
);

  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int PW  = $clog2(TXQ_DEPTH);
  localparam logic [PW:0] c_TXQ_FULL = (PW+1)'(TXQ_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_x   [NREG];
  logic [31:0]   r_mem [MEM_DEPTH];
  logic          r_intr_en;
  logic [31:0]   r_intr_pc;
  logic [31:0]   r_intr_vec;
  logic [7:0]    r_txq [TXQ_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_cnt;
  logic [7:0]    r_rx_data;
  logic          r_rx_pend;

  logic [31:0] w_x_rs1;
  logic        w_full;
  logic        w_tx_valid;
  logic        w_push_req;
  logic        w_pop;
  logic        w_push;

  // Upper address bits are architecturally ignored.
  logic w_unused;
  assign w_unused = &{1'b0, i_ex.mem_addr[31:MAW]};

  // ---------------- read ports (pre-edge state, no bypass) ----------------
  assign w_x_rs1  = (i_rs1_idx == 4'd0) ? 32'd0 : r_x[i_rs1_idx];
  assign o_x_rs1  = w_x_rs1;
  assign o_x_rs2  = (i_rs2_idx == 4'd0) ? 32'd0 : r_x[i_rs2_idx];
  assign o_mem_rd = r_mem[w_x_rs1[MAW-1:0]];

  assign o_pc       = r_pc;
  assign o_intr_en  = r_intr_en;
  assign o_intr_pc  = r_intr_pc;
  assign o_intr_vec = r_intr_vec;

  // ---------------- architectural state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_intr_en  <= 1'b0;
      r_intr_pc  <= 32'd0;
      r_intr_vec <= RESET_VEC;
      for (int i = 0; i < NREG; i++)      r_x[i]   <= 32'd0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (i_ex_valid) begin
      r_pc       <= i_ex.pc;
      r_intr_en  <= i_ex.intr_en;
      r_intr_pc  <= i_ex.intr_pc;
      r_intr_vec <= i_ex.intr_vec;
      if (i_ex.w_rd && (i_rd_idx != 4'd0)) r_x[i_rd_idx] <= i_ex.x_rd;
      if (i_ex.mem_w_req) r_mem[i_ex.mem_addr[MAW-1:0]] <= i_ex.mem_val;
    end
  end

  // ---------------- TX queue ----------------
  assign w_full     = (r_cnt == c_TXQ_FULL);
  assign w_tx_valid = (r_cnt != '0);
  assign w_push_req = i_ex_valid & i_ex.w_req;
  assign w_pop      = w_tx_valid & i_tx_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);

  assign o_w_busy   = w_full;
  assign o_tx_valid = w_tx_valid;
  assign o_tx_data  = w_tx_valid ? r_txq[r_rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < TXQ_DEPTH; i++) r_txq[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_txq[r_wr_ptr] <= i_ex.w_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- RX latch ----------------
  // A fresh byte outranks an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_data <= 8'h00;
      r_rx_pend <= 1'b0;
    end else if (i_rx_valid) begin
      r_rx_data <= i_rx_data;
      r_rx_pend <= 1'b1;
    end else if (i_ex_valid && i_ex.ack) begin
      r_rx_pend <= 1'b0;
    end
  end

  assign o_r_data   = r_rx_data;
  assign o_intr_req = r_rx_pend & r_intr_en;

endmodule
`default_nettype wire
